// File: rtl/wb_initiator.sv
// wb_initiator
// Single-outstanding Wishbone pipelined-mode initiator. A command taken from
// the local valid/ready port becomes exactly one Wishbone transaction. Its
// outcome is returned as a one-cycle response pulse. A bounded ack timeout
// keeps an unmapped address from hanging the block.
//
// Optional feature macro: WB_INITIATOR_ERR_EN
//   When defined, an i_wb_err input is added. A bus error terminates the
//   transaction like an ack, but reports rsp_err=1 and rsp_data=ERR_DATA.
//
// Parameters:
//   TIMEOUT_CYCLES  number of cycles in REQ+WAIT without ack before abort (2..65535)
//   ERR_DATA        value returned on rsp_data for an aborted transaction
//
// Ports:
//   clk          single clock, all logic on posedge
//   reset        asynchronous, active-low reset
//   cmd_valid    command present
//   cmd_ready    command accepted when high (only in IDLE)
//   cmd_we       1 = write, 0 = read
//   cmd_addr     byte address
//   cmd_data     write data (ignored for reads)
//   rsp_valid    one-cycle response pulse
//   rsp_data     read data, held until the next response; 0 after writes
//   rsp_err      aborted transaction, qualified by rsp_valid
//   o_wb_cyc/o_wb_stb/o_wb_we/o_wb_addr/o_wb_data   Wishbone request
//   i_wb_ack/i_wb_stall/i_wb_data (/i_wb_err)       Wishbone response
module wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
`ifdef WB_INITIATOR_ERR_EN
    input  logic        i_wb_err,
`endif
    input  logic [31:0] i_wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    // The counter holds the number of completed REQ/WAIT cycles. On the edge
    // where it equals TIMEOUT_CYCLES-1, the bus has been held for exactly
    // TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] count;
    logic        bus_err;
    logic        terminate;
    logic        expired;

`ifdef WB_INITIATOR_ERR_EN
    assign bus_err = i_wb_err;
`else
    assign bus_err = 1'b0;
`endif

    assign cmd_ready = (state == ST_IDLE);

    // In REQ, an ack or error is only meaningful when the strobe is accepted
    // on the same edge. A terminating response beats a simultaneous timeout.
    assign terminate = (i_wb_ack || bus_err) &&
                       (((state == ST_REQ) && !i_wb_stall) || (state == ST_WAIT));
    assign expired   = !terminate && (count == TIMEOUT_LAST) &&
                       ((state == ST_REQ) || (state == ST_WAIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= 16'd0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= 32'd0;
            o_wb_data <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (terminate) begin
                // Error takes priority over ack when both are asserted.
                o_wb_cyc  <= 1'b0;
                o_wb_stb  <= 1'b0;
                state     <= ST_IDLE;
                rsp_valid <= 1'b1;
                rsp_err   <= bus_err;
                if (bus_err) begin
                    rsp_data <= ERR_DATA;
                end else if (o_wb_we) begin
                    rsp_data <= 32'd0;
                end else begin
                    rsp_data <= i_wb_data;
                end
            end else if (expired) begin
                o_wb_cyc  <= 1'b0;
                o_wb_stb  <= 1'b0;
                state     <= ST_IDLE;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_data  <= ERR_DATA;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_valid) begin
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= cmd_we;
                            o_wb_addr <= cmd_addr;
                            o_wb_data <= cmd_data;
                            count     <= 16'd0;
                            state     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        count <= count + 16'd1;
                        if (!i_wb_stall) begin
                            o_wb_stb <= 1'b0;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        count <= count + 16'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator
// Self-checking bench for wb_initiator. Directed commands push their
// hand-computed response into a scoreboard queue. A monitor pops and compares
// on every rsp_valid pulse. A configurable responder model provides stall,
// registered ack, never-ack and stray-ack behaviour.
module tb_wb_initiator;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic        i_wb_err;
    logic [31:0] i_wb_data;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          stb_cycles;
        int          latency;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int failures = 0;
    int rsp_count = 0;

    // Responder configuration, written by the stimulus
    int cfg_stall = 0;
    bit cfg_never_ack = 0;
    bit cfg_err = 0;
    bit stray_req = 0;

    // Responder internal state
    int          stall_left = 0;
    bit          in_stb = 0;
    bit          ack_next = 0;
    logic [31:0] resp_addr = 32'd0;

    // Monitor state
    bit          active = 0;
    int          lat = 0;
    int          stb_cnt = 0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_addr = 32'd0;
    logic [31:0] cap_data = 32'd0;

    wb_initiator #(
        .TIMEOUT_CYCLES(8),
        .ERR_DATA      (ERR_DATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_addr (o_wb_addr),
        .o_wb_data (o_wb_data),
        .i_wb_ack  (i_wb_ack),
        .i_wb_stall(i_wb_stall),
`ifdef WB_INITIATOR_ERR_EN
        .i_wb_err  (i_wb_err),
`endif
        .i_wb_data (i_wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        case (addr)
            32'h3000_0004: mem_read = 32'h0000_0003;
            32'h3000_0008: mem_read = 32'h0000_00A5;
            default:       mem_read = 32'h1122_3344;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Responder: decides stall/ack on the negedge for the following posedge.
    // An accepted strobe is acked one cycle later, which models a registered ack.
    always @(negedge clk) begin
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (!reset) begin
            ack_next   = 1'b0;
            in_stb     = 1'b0;
            i_wb_stall = 1'b0;
        end else begin
            if (ack_next) begin
                ack_next = 1'b0;
                if (!cfg_never_ack) begin
                    if (cfg_err) i_wb_err = 1'b1;
                    else         i_wb_ack = 1'b1;
                    i_wb_data = mem_read(resp_addr);
                end
            end
            if (stray_req) begin
                stray_req = 1'b0;
                i_wb_ack  = 1'b1;
                i_wb_data = 32'hBAD0_BAD0;
            end
            if (o_wb_cyc && o_wb_stb) begin
                if (!in_stb) begin
                    in_stb     = 1'b1;
                    stall_left = cfg_stall;
                end
                if (stall_left > 0) begin
                    i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    i_wb_stall = 1'b0;
                    ack_next   = 1'b1;
                    resp_addr  = o_wb_addr;
                end
            end else begin
                in_stb     = 1'b0;
                i_wb_stall = 1'b0;
            end
        end
    end

    // Monitor: checks the bus against the accepted command and scores responses
    always @(negedge clk) begin
        if (!reset) begin
            active = 1'b0;
        end else begin
            if (active) lat++;
            if (o_wb_stb) begin
                stb_cnt++;
                checkOutput("stb_implies_cyc", 32'(o_wb_cyc), 32'd1);
                checkOutput("bus_we", 32'(o_wb_we), 32'(cap_we));
                checkOutput("bus_addr", o_wb_addr, cap_addr);
                checkOutput("bus_data", o_wb_data, cap_data);
            end
            if (o_wb_cyc) begin
                checkOutput("single_outstanding", 32'(cmd_ready), 32'd0);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected no response");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                    checkOutput("stb_cycles", 32'(stb_cnt), 32'(e.stb_cycles));
                    checkOutput("rsp_latency", 32'(lat), 32'(e.latency));
                end
                active = 1'b0;
                rsp_count++;
            end
            if (cmd_valid && cmd_ready) begin
                cap_we   = cmd_we;
                cap_addr = cmd_addr;
                cap_data = cmd_we ? cmd_data : 32'd0;
                active   = 1'b1;
                lat      = 0;
                stb_cnt  = 0;
            end
        end
    end

    task automatic waitAccept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("accept_within_bound", 32'(ok), 32'd1);
    endtask

    task automatic waitResponse(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (rsp_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("rsp_within_bound", 32'(ok), 32'd1);
    endtask

    task automatic pushExpect(input logic [31:0] data, input logic err,
                              input int stb_cycles, input int latency);
        exp_t e;
        e.data       = data;
        e.err        = err;
        e.stb_cycles = stb_cycles;
        e.latency    = latency;
        sb.push_back(e);
    endtask

    // Issue one command and wait for its response.
    // Latency counts cycles from the accept cycle: the accept cycle is 0 and
    // the first REQ cycle is 1.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input int stall,
                                 input bit never_ack, input bit err_mode,
                                 input logic [31:0] exp_data, input logic exp_err,
                                 input int exp_stb, input int exp_lat);
        int target;
        cfg_stall     = stall;
        cfg_never_ack = never_ack;
        cfg_err       = err_mode;
        pushExpect(exp_data, exp_err, exp_stb, exp_lat);
        target = rsp_count + 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
        waitAccept();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        waitResponse(target);
    endtask

    initial begin
        int target;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 32'd0;
        cmd_data  = 32'd0;
        i_wb_ack   = 1'b0;
        i_wb_stall = 1'b0;
        i_wb_err   = 1'b0;
        i_wb_data  = 32'd0;
        #2 reset = 1'b0;
        #1;
        checkOutput("reset_cyc", 32'(o_wb_cyc), 32'd0);
        checkOutput("reset_stb", 32'(o_wb_stb), 32'd0);
        checkOutput("reset_we", 32'(o_wb_we), 32'd0);
        checkOutput("reset_addr", o_wb_addr, 32'd0);
        checkOutput("reset_data", o_wb_data, 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_rsp_data", rsp_data, 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Zero-stall write
        applyStimulus(1'b1, 32'h3000_0000, 32'h0000_0002, 0, 1'b0, 1'b0,
                      32'h0000_0000, 1'b0, 1, 3);
        // Read with stall held for 4 cycles
        applyStimulus(1'b0, 32'h3000_0004, 32'h0, 4, 1'b0, 1'b0,
                      32'h0000_0003, 1'b0, 5, 7);
        // Never-acked read times out after 8 cycles
        applyStimulus(1'b0, 32'h3000_0100, 32'h0, 0, 1'b1, 1'b0,
                      ERR_DATA, 1'b1, 1, 9);
        // Ack on the same edge as the timeout wins
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 6, 1'b0, 1'b0,
                      32'h0000_00A5, 1'b0, 7, 9);
        // Strobe accepted on the timeout edge without ack: aborted, late ack ignored
        applyStimulus(1'b0, 32'h3000_000C, 32'h0, 7, 1'b0, 1'b0,
                      ERR_DATA, 1'b1, 8, 9);

        // Back-to-back commands with cmd_valid held
        cfg_stall     = 0;
        cfg_never_ack = 1'b0;
        cfg_err       = 1'b0;
        pushExpect(32'h0000_0000, 1'b0, 1, 3);
        pushExpect(32'h0000_0003, 1'b0, 1, 3);
        target = rsp_count + 2;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 32'h3000_0000;
        cmd_data  = 32'h0000_0005;
        waitAccept();
        @(posedge clk);
        #1;
        cmd_we   = 1'b0;
        cmd_addr = 32'h3000_0004;
        cmd_data = 32'h0000_0000;
        waitAccept();
        checkOutput("b2b_accept_in_rsp_cycle", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        waitResponse(target);

        // Stray ack while idle produces no response
        @(posedge clk);
        #1 stray_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stray_ack_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Reset asserted while in WAIT
        cfg_stall     = 0;
        cfg_never_ack = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h3000_0100;
        waitAccept();
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkOutput("mid_reset_cyc", 32'(o_wb_cyc), 32'd0);
        checkOutput("mid_reset_stb", 32'(o_wb_stb), 32'd0);
        checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 0, 1'b0, 1'b0,
                      32'h0000_00A5, 1'b0, 1, 3);

`ifdef WB_INITIATOR_ERR_EN
        // Bus error in place of ack on a read
        applyStimulus(1'b0, 32'h3000_0004, 32'h0, 0, 1'b0, 1'b1,
                      ERR_DATA, 1'b1, 1, 3);
`endif

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
